// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants, state type and NOP helper for the program loader
package imem_loader_pkg;

  localparam logic [7:0]  LOADER_HEADER   = 8'hA5;
  localparam logic [31:0] NOP_INSTRUCTION = 32'hE000_0000;
  // Wide enough for byte counts up to 262140 plus one.
  localparam int          CNT_W           = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_FILL,
    ST_DONE,
    ST_ERR
  } state_t;

  // Big-endian lane select: lane 0 holds instruction bits [31:24].
  function automatic logic [7:0] nop_byte(input logic [1:0] lane);
    return NOP_INSTRUCTION[{~lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - valid/ready byte stream from the host link into the loader
interface imem_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - receives a framed program image and writes it byte-wise into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_SIZE = 16,
  parameter int ADDR_W   = 32,
  parameter int WORD_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  imem_loader_if.slave        host,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  localparam logic [CNT_W-1:0] MEM_BYTES = CNT_W'(MEM_SIZE);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [15:0]         nwords, nwords_n;
  logic [7:0]          sum, sum_n;
  logic                rdy_n, we_n, done_n, error_n, hold_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [WORD_LEN-1:0] wdata_n;
  logic [15:0]         len_rx;
  logic [CNT_W-1:0]    len_bytes, total;
  logic                acc;

  assign acc       = host.in_valid & host.in_ready;
  assign total     = {nwords, 2'b00};
  assign len_rx    = {nwords[15:8], host.in_data};
  assign len_bytes = {len_rx, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      nwords        <= '0;
      sum           <= '0;
      host.in_ready <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      nwords        <= nwords_n;
      sum           <= sum_n;
      host.in_ready <= rdy_n;
      mem_we        <= we_n;
      mem_addr      <= addr_n;
      mem_wdata     <= wdata_n;
      cpu_hold      <= hold_n;
      done          <= done_n;
      error         <= error_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    nwords_n = nwords;
    sum_n    = sum;
    we_n     = 1'b0;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;
    done_n   = done;
    error_n  = error;
    hold_n   = cpu_hold;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (acc && host.in_data == LOADER_HEADER) begin
          state_n = ST_LEN_HI;
          done_n  = 1'b0;
          error_n = 1'b0;
          hold_n  = 1'b1;
          sum_n   = '0;
          cnt_n   = '0;
        end
      end
      ST_LEN_HI: begin
        if (acc) begin
          nwords_n = {host.in_data, 8'h00};
          state_n  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (acc) begin
          nwords_n = len_rx;
          if (len_rx == 16'd0 || len_bytes > MEM_BYTES) begin
            state_n = ST_ERR;
            error_n = 1'b1;
          end else begin
            state_n = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (acc) begin
          we_n    = 1'b1;
          addr_n  = ADDR_W'(cnt);
          wdata_n = WORD_LEN'(host.in_data);
          sum_n   = sum + host.in_data;
          cnt_n   = cnt + CNT_W'(1);
          if (cnt == total - CNT_W'(1)) state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // cnt already equals 4N here, so FILL starts from the first unloaded byte.
        if (acc) begin
          if (host.in_data != sum) begin
            state_n = ST_ERR;
            error_n = 1'b1;
          end else if (total == MEM_BYTES) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end else begin
            state_n = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        we_n    = 1'b1;
        addr_n  = ADDR_W'(cnt);
        wdata_n = WORD_LEN'(nop_byte(cnt[1:0]));
        cnt_n   = cnt + CNT_W'(1);
        if (cnt == MEM_BYTES - CNT_W'(1)) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
          hold_n  = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    rdy_n = (state_n != ST_FILL);
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for the program loader with a 16-byte memory
module tb_imem_loader;

  localparam int MEM = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;

  imem_loader_if bus();

  imem_loader #(.MEM_SIZE(MEM), .ADDR_W(32), .WORD_LEN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          wr_total = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  img [16] = '{8'hE3, 8'hA0, 8'h00, 8'h14, 8'hE3, 8'hA0, 8'h10, 8'h04,
                            8'h5C, 8'h17, 8'hC3, 8'h9E, 8'h01, 8'hFF, 8'h7A, 8'h42};
  logic [31:0] nop = 32'hE000_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_we) begin
      logic [39:0] e;
      wr_total++;
      if (exp_q.size() == 0) begin
        check("spurious_wr", mem_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e[39:8]);
        check("wr_data", {24'h0, mem_wdata}, {24'h0, e[7:0]});
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", {31'h0, bus.in_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic load(input int n, input int bad, input int gap);
    logic [7:0]  s;
    logic [15:0] nw;
    int          base, nb, wait_n;
    bit          ok;
    s    = 8'h00;
    nw   = n[15:0];
    nb   = 4 * n;
    base = wr_total;
    send(8'hA5, 0);
    check("hdr_hold", {31'h0, cpu_hold}, 32'h1);
    check("hdr_done", {31'h0, done}, 32'h0);
    send(nw[15:8], 0);
    send(nw[7:0], 0);
    if (n == 0 || nb > MEM) begin
      repeat (3) @(negedge clk);
      check("len_error", {31'h0, error}, 32'h1);
      check("len_hold", {31'h0, cpu_hold}, 32'h1);
      check("len_writes", wr_total - base, 0);
      return;
    end
    for (int k = 0; k < nb; k++) begin
      exp_q.push_back({k[31:0], img[k]});
      s = s + img[k];
      send(img[k], (gap > 0) ? $urandom_range(0, gap) : 0);
    end
    ok = (bad == 0);
    if (ok)
      for (int a = nb; a < MEM; a++) exp_q.push_back({a[31:0], nop[8*(3-(a%4)) +: 8]});
    send(s + bad[7:0], 0);
    if (ok && nb == MEM) check("full_direct_done", {31'h0, done}, 32'h1);
    wait_n = 0;
    while (!(done || error) && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    if (wait_n >= 100) check("end_timeout", wait_n, 0);
    repeat (2) @(negedge clk);
    check("done", {31'h0, done}, {31'h0, ok});
    check("error", {31'h0, error}, {31'h0, !ok});
    check("hold", {31'h0, cpu_hold}, {31'h0, !ok});
    check("ready_after", {31'h0, bus.in_ready}, 32'h1);
    check("writes", wr_total - base, ok ? MEM : nb);
    check("q_empty", exp_q.size(), 0);
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, bus.in_ready}, 32'h0);
    check("rst_hold", {31'h0, cpu_hold}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_error", {31'h0, error}, 32'h0);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'h0, bus.in_ready}, 32'h1);

    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h5A, 0);
    check("garbage_writes", wr_total, 0);
    load(2, 0, 0);
    load(2, 1, 0);
    load(0, 0, 0);
    load(5, 0, 0);
    load(4, 0, 0);
    load(2, 0, 3);

    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h02, 0);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({k[31:0], img[k]});
      send(img[k], 0);
    end
    #2 rst = 1'b1;
    #1;
    check("abort_ready", {31'h0, bus.in_ready}, 32'h0);
    check("abort_hold", {31'h0, cpu_hold}, 32'h1);
    check("abort_we", {31'h0, mem_we}, 32'h0);
    check("abort_addr", mem_addr, 32'h0);
    check("abort_q", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
